// File: rtl/cmd_mem_pkg.sv
// Shared types and constants for the command memory
// and the time-driven scheduler that drains it.
package cmd_mem_pkg;

  localparam int CMD_W     = 338;
  localparam int TIME_MSB  = 337;
  localparam int TIME_LSB  = 274;
  localparam int PAYLOAD_W = 274;

  localparam logic [63:0] EMPTY_TIME = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CHK,
    S_DISP,
    S_CLR,
    S_NEXT
  } sched_state_t;

endpackage

// File: rtl/cmd_time_scheduler_if.sv
// Scheduler bus: memory read port, command hand-off
// and slot-erase handshake. master = scheduler side.
interface cmd_time_scheduler_if
  import cmd_mem_pkg::*;
#(
  parameter int AW = 8
);

  logic                 MEM_RDEN;
  logic [AW-1:0]        MEM_RD_ADDR;
  logic [CMD_W-1:0]     MEM_Q;

  logic                 CMD_VALID;
  logic                 CMD_READY;
  logic [63:0]          CMD_TIME;
  logic [PAYLOAD_W-1:0] CMD_DATA;

  logic                 CLR_REQ;
  logic [AW-1:0]        CLR_ADDR;
  logic                 CLR_ACK;

  modport master (
    output MEM_RDEN,
    output MEM_RD_ADDR,
    input  MEM_Q,
    output CMD_VALID,
    input  CMD_READY,
    output CMD_TIME,
    output CMD_DATA,
    output CLR_REQ,
    output CLR_ADDR,
    input  CLR_ACK
  );

  modport slave (
    input  MEM_RDEN,
    input  MEM_RD_ADDR,
    output MEM_Q,
    input  CMD_VALID,
    output CMD_READY,
    input  CMD_TIME,
    input  CMD_DATA,
    input  CLR_REQ,
    input  CLR_ADDR,
    output CLR_ACK
  );

endinterface

// File: rtl/cmd_due_cmp.sv
// Classifies one memory entry against system time.
// Lateness is only evaluated with CMD_LATE_DROP_EN.
module cmd_due_cmp
  import cmd_mem_pkg::*;
(
  input  logic [63:0] i_time_start,
  input  logic [63:0] i_sys_time,
  input  logic [63:0] i_late_win,
  output logic        o_empty,
  output logic        o_due,
  output logic        o_late
);

  logic [63:0] w_age;

  assign w_age   = i_sys_time - i_time_start;
  assign o_empty = (i_time_start == EMPTY_TIME);
  assign o_due   = !o_empty &&
                   (i_time_start <= i_sys_time);

`ifdef CMD_LATE_DROP_EN
  assign o_late = o_due && (w_age > i_late_win);
`else
  // Lateness check compiled out; constant low keeps
  // the port list identical in both builds.
  assign o_late = &{1'b0, w_age, i_late_win};
`endif

endmodule

// File: rtl/cmd_time_scheduler.sv
// Scans command memory, dispatches due entries and
// requests their erase. Optional: CMD_LATE_DROP_EN.
module cmd_time_scheduler
  import cmd_mem_pkg::*;
#(
  parameter int          N_IDX    = 256,
  parameter int          MEM_LAT  = 2,
  parameter logic [63:0] LATE_WIN = 64'd1000
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        EN,
  input  logic [63:0] SYS_TIME,
  cmd_time_scheduler_if.master bus,
  output logic [15:0] MISS_CNT,
  output logic        BUSY
);

  localparam int AW = $clog2(N_IDX);
  localparam logic [2:0] WAIT_LAST =
    (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;
  localparam logic [AW-1:0] LAST_IDX =
    AW'(N_IDX - 1);

  sched_state_t     r_state;
  sched_state_t     w_next;
  logic [AW-1:0]    r_addr;
  logic [2:0]       r_wcnt;
  logic [CMD_W-1:0] r_hold;
  logic             w_empty;
  logic             w_due;
  logic             w_late;
  logic             w_drop;

  cmd_due_cmp u_cmp (
    .i_time_start (bus.MEM_Q[TIME_MSB:TIME_LSB]),
    .i_sys_time   (SYS_TIME),
    .i_late_win   (LATE_WIN),
    .o_empty      (w_empty),
    .o_due        (w_due),
    .o_late       (w_late)
  );

  assign w_drop = (r_state == S_CHK) &&
                  w_due && w_late;

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (EN) w_next = S_RD;
      S_RD:
        w_next = (MEM_LAT == 1) ? S_CHK : S_WAIT;
      S_WAIT:
        if (r_wcnt == WAIT_LAST) w_next = S_CHK;
      S_CHK: begin
        if (w_empty)     w_next = S_NEXT;
        else if (w_drop) w_next = S_CLR;
        else if (w_due)  w_next = S_DISP;
        else             w_next = S_NEXT;
      end
      S_DISP:
        if (bus.CMD_READY) w_next = S_CLR;
      S_CLR:
        if (bus.CLR_ACK) w_next = S_NEXT;
      S_NEXT: w_next = EN ? S_RD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Scan address, latency counter, holding register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_wcnt <= '0;
      r_hold <= '0;
    end else begin
      if (r_state == S_RD)   r_wcnt <= '0;
      if (r_state == S_WAIT) r_wcnt <= r_wcnt + 3'd1;
      if (r_state == S_CHK)  r_hold <= bus.MEM_Q;
      if (r_state == S_NEXT)
        r_addr <= (r_addr == LAST_IDX) ?
                  '0 : r_addr + 1'b1;
    end
  end

`ifdef CMD_LATE_DROP_EN
  logic [15:0] r_miss;

  // Saturating count of entries dropped as too late
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)
      r_miss <= '0;
    else if (w_drop && (r_miss != 16'hFFFF))
      r_miss <= r_miss + 16'd1;
  end

  assign MISS_CNT = r_miss;
`else
  assign MISS_CNT = '0;
`endif

  // State-decoded outputs, zero outside their states
  always_comb begin
    bus.MEM_RDEN    = 1'b0;
    bus.MEM_RD_ADDR = '0;
    bus.CMD_VALID   = 1'b0;
    bus.CMD_TIME    = '0;
    bus.CMD_DATA    = '0;
    bus.CLR_REQ     = 1'b0;
    bus.CLR_ADDR    = '0;
    BUSY            = (r_state != S_IDLE);
    if (r_state == S_RD) begin
      bus.MEM_RDEN    = 1'b1;
      bus.MEM_RD_ADDR = r_addr;
    end
    if (r_state == S_DISP) begin
      bus.CMD_VALID = 1'b1;
      bus.CMD_TIME  = r_hold[TIME_MSB:TIME_LSB];
      bus.CMD_DATA  = r_hold[PAYLOAD_W-1:0];
    end
    if (r_state == S_CLR) begin
      bus.CLR_REQ  = 1'b1;
      bus.CLR_ADDR = r_addr;
    end
  end

endmodule

// File: tb/tb_cmd_time_scheduler.sv
// Directed bench for cmd_time_scheduler with a
// 2-cycle memory model and an auto-acking writer.
module tb_cmd_time_scheduler;
  import cmd_mem_pkg::*;

  localparam int N   = 256;
  localparam int LAT = 2;
  localparam logic [63:0] LW = 64'd100;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        EN = 1'b0;
  logic [63:0] sys_time;
  logic [15:0] miss;
  logic        busy;

  logic        ready = 1'b0;
  logic        auto_ack = 1'b0;
  logic        time_run = 1'b0;
  logic [63:0] time_set = 64'd0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  cmd_time_scheduler_if #(.AW(8)) bus();

  cmd_time_scheduler #(
    .N_IDX(N), .MEM_LAT(LAT), .LATE_WIN(LW)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .EN(EN),
    .SYS_TIME(sys_time), .bus(bus.master),
    .MISS_CNT(miss), .BUSY(busy)
  );

  always #5 CLK = ~CLK;

  logic [CMD_W-1:0] mem [N];
  logic [CMD_W-1:0] p1, q;

  always @(posedge CLK) begin
    if (bus.MEM_RDEN) p1 <= mem[bus.MEM_RD_ADDR];
    q <= p1;
  end
  assign bus.MEM_Q = q;
  assign bus.CMD_READY = ready;

  always @(posedge CLK) begin
    sys_time <= time_run ? sys_time + 64'd1 : time_set;
    cyc <= cyc + 1;
  end

  logic [63:0]          d_time[$];
  logic [PAYLOAD_W-1:0] d_data[$];
  logic [63:0]          d_sys[$];
  int d_cyc[$];
  int c_addr[$];
  int c_cyc[$];
  int rd_log[$];
  int vcyc = 0;

  always @(negedge CLK) begin
    if (auto_ack && bus.CLR_REQ && !bus.CLR_ACK) begin
      bus.CLR_ACK = 1'b1;
      mem[bus.CLR_ADDR][TIME_MSB:TIME_LSB] = EMPTY_TIME;
      c_addr.push_back(int'(bus.CLR_ADDR));
      c_cyc.push_back(cyc);
    end else begin
      bus.CLR_ACK = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (bus.MEM_RDEN) rd_log.push_back(int'(bus.MEM_RD_ADDR));
    if (bus.CMD_VALID) vcyc++;
    if (bus.CMD_VALID && bus.CMD_READY) begin
      d_time.push_back(bus.CMD_TIME);
      d_data.push_back(bus.CMD_DATA);
      d_sys.push_back(sys_time);
      d_cyc.push_back(cyc);
    end
  end

  function automatic logic [PAYLOAD_W-1:0] pay(input int s);
    logic [31:0] w;
    w = 32'hA5A5_0000 | 32'(s);
    return {18'h3C3C3, {8{w}}};
  endfunction

  task automatic fill_empty();
    for (int i = 0; i < N; i++) mem[i] = {EMPTY_TIME, pay(i)};
  endtask

  task automatic clear_logs();
    d_time.delete(); d_data.delete(); d_sys.delete();
    d_cyc.delete(); c_addr.delete(); c_cyc.delete();
    rd_log.delete(); vcyc = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    rst_n = 1'b0; EN = 1'b0; ready = 1'b0;
    auto_ack = 1'b0; time_run = 1'b0;
    step(3);
    clear_logs();
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 20) begin step(1); n++; end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: busy=%0b want 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    rst_n = 1'b0;
    #2;
    total += 9;
    if (bus.MEM_RDEN !== 1'b0) begin bad++;
      $display("FAIL rst rden got %0b want 0", bus.MEM_RDEN); end
    if (bus.MEM_RD_ADDR !== 8'd0) begin bad++;
      $display("FAIL rst addr got %0d want 0", bus.MEM_RD_ADDR); end
    if (bus.CMD_VALID !== 1'b0) begin bad++;
      $display("FAIL rst valid got %0b want 0", bus.CMD_VALID); end
    if (bus.CMD_TIME !== 64'd0) begin bad++;
      $display("FAIL rst time got %0h want 0", bus.CMD_TIME); end
    if (bus.CMD_DATA !== '0) begin bad++;
      $display("FAIL rst data got nonzero want 0"); end
    if (bus.CLR_REQ !== 1'b0) begin bad++;
      $display("FAIL rst clrreq got %0b want 0", bus.CLR_REQ); end
    if (bus.CLR_ADDR !== 8'd0) begin bad++;
      $display("FAIL rst clraddr got %0d want 0", bus.CLR_ADDR); end
    if (miss !== 16'd0) begin bad++;
      $display("FAIL rst miss got %0d want 0", miss); end
    if (busy !== 1'b0) begin bad++;
      $display("FAIL rst busy got %0b want 0", busy); end
    step(2);
    rst_n = 1'b1;
    step(5);
    total++;
    if (busy !== 1'b0 || bus.MEM_RDEN !== 1'b0) begin bad++;
      $display("FAIL idle_noen busy=%0b rden=%0b want 0 0",
               busy, bus.MEM_RDEN); end
  endtask

  task automatic test_empty_scan();
    int wraps = 0;
    int steps_bad = 0;
    int last;
    fill_empty();
    do_reset();
    ready = 1'b1; auto_ack = 1'b1;
    EN = 1'b1;
    step(2100);
    EN = 1'b0;
    wait_idle("scan");
    for (int i = 1; i < rd_log.size(); i++) begin
      if (rd_log[i-1] == 255 && rd_log[i] == 0) wraps++;
      else if (rd_log[i] != rd_log[i-1] + 1) steps_bad++;
    end
    total += 5;
    if (rd_log.size() == 0 || rd_log[0] != 0) begin bad++;
      $display("FAIL scan_first size=%0d want first addr 0",
               rd_log.size()); end
    if (wraps != 2) begin bad++;
      $display("FAIL scan_wraps got %0d want 2", wraps); end
    if (steps_bad != 0) begin bad++;
      $display("FAIL scan_steps got %0d bad want 0", steps_bad); end
    if (vcyc != 0) begin bad++;
      $display("FAIL scan_valid got %0d want 0", vcyc); end
    if (c_addr.size() != 0) begin bad++;
      $display("FAIL scan_clr got %0d want 0", c_addr.size()); end
    last = (rd_log.size() > 0) ? rd_log[$] : 0;
    rd_log.delete();
    EN = 1'b1;
    step(3);
    EN = 1'b0;
    wait_idle("resume");
    total++;
    if (rd_log.size() == 0 ||
        rd_log[0] != ((last + 1) % N)) begin bad++;
      $display("FAIL scan_keep got %0d want %0d",
               (rd_log.size() > 0) ? rd_log[0] : -1,
               (last + 1) % N); end
  endtask

  task automatic test_dispatch();
    int n = 0;
    fill_empty();
    mem[5] = {64'd1000, pay(5)};
    do_reset();
    ready = 1'b1; auto_ack = 1'b1;
    time_run = 1'b1; EN = 1'b1;
    while (c_addr.size() == 0 && n < 3000) begin
      step(1); n++;
    end
    step(1200);
    EN = 1'b0;
    wait_idle("disp");
    total += 7;
    if (d_time.size() != 1) begin bad++;
      $display("FAIL disp_count got %0d want 1", d_time.size()); end
    if (d_time.size() == 0 || d_time[0] !== 64'd1000) begin bad++;
      $display("FAIL disp_time want 1000"); end
    if (d_data.size() == 0 || d_data[0] !== pay(5)) begin bad++;
      $display("FAIL disp_data mismatched payload want slot 5"); end
    if (d_sys.size() == 0 || d_sys[0] < 64'd1000) begin bad++;
      $display("FAIL disp_early dispatched before time 1000"); end
    if (c_addr.size() != 1 || c_addr[0] != 5) begin bad++;
      $display("FAIL disp_clr count=%0d want one erase of 5",
               c_addr.size()); end
    if (c_cyc.size() == 0 || d_cyc.size() == 0 ||
        c_cyc[0] != d_cyc[0] + 1) begin bad++;
      $display("FAIL disp_clr_lat want erase 1 cycle after hs"); end
    if (vcyc != 1) begin bad++;
      $display("FAIL disp_vlen got %0d want 1", vcyc); end
    time_run = 1'b0;
  endtask

  task automatic test_stall();
    int n = 0;
    fill_empty();
    mem[9] = {64'd1950, pay(9)};
    do_reset();
    time_set = 64'd2000;
    step(1);
    auto_ack = 1'b1; ready = 1'b0;
    EN = 1'b1;
    while (!bus.CMD_VALID && n < 100) begin step(1); n++; end
    total++;
    if (bus.CMD_VALID !== 1'b1) begin bad++;
      $display("FAIL stall_start valid=%0b want 1", bus.CMD_VALID); end
    for (int i = 0; i < 50; i++) begin
      total++;
      if (bus.CMD_VALID !== 1'b1 || bus.CMD_DATA !== pay(9) ||
          bus.CMD_TIME !== 64'd1950 || bus.CLR_REQ !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold c%0d valid=%0b time=%0d clr=%0b want 1 1950 0",
                 i, bus.CMD_VALID, bus.CMD_TIME, bus.CLR_REQ);
      end
      step(1);
    end
    ready = 1'b1;
    step(10);
    EN = 1'b0;
    wait_idle("stall");
    total += 2;
    if (d_time.size() != 1) begin bad++;
      $display("FAIL stall_disp got %0d want 1", d_time.size()); end
    if (c_addr.size() != 1 || c_addr[0] != 9) begin bad++;
      $display("FAIL stall_clr count=%0d want one erase of 9",
               c_addr.size()); end
  endtask

  task automatic test_late();
    fill_empty();
    mem[7] = {64'd10, pay(7)};
    do_reset();
    time_set = 64'd500;
    step(1);
    ready = 1'b1; auto_ack = 1'b1;
    EN = 1'b1;
    step(100);
    EN = 1'b0;
    wait_idle("late");
    total += 3;
`ifdef CMD_LATE_DROP_EN
    if (d_time.size() != 0) begin bad++;
      $display("FAIL late_nodisp got %0d want 0", d_time.size()); end
    if (miss !== 16'd1) begin bad++;
      $display("FAIL late_miss got %0d want 1", miss); end
`else
    if (d_time.size() != 1 || d_time[0] !== 64'd10) begin bad++;
      $display("FAIL late_disp count=%0d want one at time 10",
               d_time.size()); end
    if (miss !== 16'd0) begin bad++;
      $display("FAIL late_miss got %0d want 0", miss); end
`endif
    if (c_addr.size() != 1 || c_addr[0] != 7) begin bad++;
      $display("FAIL late_clr count=%0d want one erase of 7",
               c_addr.size()); end
  endtask

  task automatic test_back_to_back();
    fill_empty();
    mem[3] = {64'd240, pay(3)};
    mem[4] = {64'd245, pay(4)};
    do_reset();
    time_set = 64'd250;
    step(1);
    ready = 1'b1; auto_ack = 1'b1;
    EN = 1'b1;
    step(100);
    EN = 1'b0;
    wait_idle("b2b");
    total += 4;
    if (d_time.size() != 2) begin bad++;
      $display("FAIL b2b_count got %0d want 2", d_time.size()); end
    if (d_time.size() < 2 || d_time[0] !== 64'd240 ||
        d_time[1] !== 64'd245 || d_data[1] !== pay(4)) begin bad++;
      $display("FAIL b2b_order want times 240 then 245"); end
    if (c_addr.size() != 2 || c_addr[0] != 3 ||
        c_addr[1] != 4) begin bad++;
      $display("FAIL b2b_clr count=%0d want erases 3 then 4",
               c_addr.size()); end
    if (c_cyc.size() == 0 || d_cyc.size() < 2 ||
        c_cyc[0] >= d_cyc[1]) begin bad++;
      $display("FAIL b2b_seq want slot 3 erased before slot 4 hs"); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fill_empty();
    mem[2] = {64'd100, pay(2)};
    do_reset();
    time_set = 64'd150;
    step(1);
    ready = 1'b1; auto_ack = 1'b0;
    EN = 1'b1;
    while (!bus.CLR_REQ && n < 100) begin step(1); n++; end
    total++;
    if (bus.CLR_REQ !== 1'b1 || bus.CLR_ADDR !== 8'd2) begin bad++;
      $display("FAIL mid_clr req=%0b addr=%0d want 1 2",
               bus.CLR_REQ, bus.CLR_ADDR); end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.CLR_REQ !== 1'b0 || bus.CLR_ADDR !== 8'd0 ||
        bus.CMD_VALID !== 1'b0 || bus.MEM_RDEN !== 1'b0 ||
        busy !== 1'b0) begin bad++;
      $display("FAIL mid_rst req=%0b addr=%0d valid=%0b busy=%0b want 0",
               bus.CLR_REQ, bus.CLR_ADDR, bus.CMD_VALID, busy); end
    EN = 1'b0;
    step(2);
    clear_logs();
    rst_n = 1'b1;
    step(1);
    EN = 1'b1;
    step(3);
    EN = 1'b0;
    wait_idle("mid");
    total++;
    if (rd_log.size() == 0 || rd_log[0] != 0) begin bad++;
      $display("FAIL mid_restart got %0d want addr 0",
               (rd_log.size() > 0) ? rd_log[0] : -1); end
  endtask

  initial begin
    fill_empty();
    test_reset();
    test_empty_scan();
    test_dispatch();
    test_stall();
    test_late();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_time_scheduler.md
# cmd_time_scheduler

Time-driven sequencer for the 256-entry command register memory filled by the SPI command writer. Continuously scans the memory read port, compares each occupied entry's TIME_START against the system time counter, and hands due commands to the pulse/frequency generator over a valid/ready handshake. After each hand-off it asks the writer to erase the slot. Sits between the command memory and the generator.

## Interface
- N_IDX, 256, number of memory entries; address width AW = $clog2(N_IDX)
- MEM_LAT, 2, memory read latency in cycles (rden to valid q), 1..4
- LATE_WIN, 64'd1000, max tolerated lateness in CLK cycles (used only with late-drop)
- CLK  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- EN  in  1  scan enable
- SYS_TIME  in  64  free-running system time, CLK domain
- MEM_RDEN  out  1  memory read strobe
- MEM_RD_ADDR  out  AW  memory read address
- MEM_Q  in  338  memory data; [337:274] TIME_START, [273:0] payload
- CMD_VALID  out  1  command available
- CMD_READY  in  1  generator accepts command
- CMD_TIME  out  64  TIME_START of dispatched command
- CMD_DATA  out  274  payload of dispatched command
- CLR_REQ  out  1  erase request to writer
- CLR_ADDR  out  AW  slot to erase
- CLR_ACK  in  1  writer has erased slot
- MISS_CNT  out  16  dropped-late count, saturating
- BUSY  out  1  high in any state except IDLE

## Operation
- States: IDLE, RD, WAIT, CHK, DISP, CLR, NEXT.
- IDLE: if EN -> RD.
- RD: MEM_RDEN=1 for one cycle, MEM_RD_ADDR=scan address -> WAIT.
- WAIT: MEM_LAT-1 cycles (0 when MEM_LAT=1) -> CHK; MEM_Q captured into a 338-bit holding register on the CHK cycle.
- CHK: entry empty when TIME_START==64'hFFFF_FFFF_FFFF_FFFF -> NEXT. Due when not empty and TIME_START <= SYS_TIME (unsigned 64-bit) -> DISP. Otherwise -> NEXT.
- DISP: CMD_VALID=1, CMD_TIME/CMD_DATA from holding register, stable until CMD_READY sampled high -> CLR.
- CLR: CLR_REQ=1, CLR_ADDR=scan address, held until CLR_ACK sampled high -> NEXT.
- NEXT: scan address +1, wraps N_IDX-1 -> 0; EN ? RD : IDLE.
- EN deasserted in DISP or CLR: current handshake completes, then IDLE. Scan address kept across IDLE.
- Future entries are left untouched; re-checked next pass.

## Timing
- Reset values: all outputs 0, state IDLE, scan address 0, holding register 0.
- Per non-due entry: MEM_LAT+2 cycles (RD, WAIT, CHK, NEXT with WAIT of MEM_LAT-1). Full pass with N_IDX=256, MEM_LAT=2: 1024 cycles.
- CMD_VALID rises the cycle after CHK; CMD_READY already high -> single-cycle VALID.
- CLR_REQ rises the cycle after VALID&READY; falls the cycle after CLR_ACK.
- CLR_ACK or CMD_READY outside their states: ignored.
- Reset asserted mid-handshake: outputs drop immediately (async); no command or erase is repeated or completed.

## Configuration
- CMD_LATE_DROP_EN defined: in CHK, a due entry with SYS_TIME - TIME_START > LATE_WIN goes straight to CLR without DISP; MISS_CNT increments, saturates at 16'hFFFF.
- Undefined: every due entry is dispatched regardless of lateness; MISS_CNT tied to 0; LATE_WIN unused.

## Structure
- Shared package cmd_mem_pkg: CMD_W=338, TIME_MSB=337, TIME_LSB=274, PAYLOAD_W=274, EMPTY_TIME constant, scheduler state enum.
- One sub-module: cmd_due_cmp, combinational, inputs TIME_START/SYS_TIME/LATE_WIN, outputs empty/due/late.

## Test plan
- All slots FFFF..: EN=1 for 2100 cycles -> MEM_RD_ADDR wraps 255->0 twice, CMD_VALID and CLR_REQ never assert.
- Slot 5 TIME_START=1000, SYS_TIME counting from 0 -> one CMD_VALID with CMD_TIME=1000 and slot 5 payload, then CLR_REQ with CLR_ADDR=5; no second dispatch after ACK.
- CMD_READY held low 50 cycles -> CMD_VALID/CMD_DATA stable for 50 cycles, no CLR_REQ until READY.
- Macro on, LATE_WIN=100, slot 7 TIME_START=10, SYS_TIME=500 -> no CMD_VALID, CLR_ADDR=7, MISS_CNT=1; macro off -> dispatched.
- Slots 3 and 4 due simultaneously -> slot 3 dispatched and cleared before slot 4.
- rst_n low during CLR -> all outputs 0 next edge, scan restarts at address 0 after EN.
